data_mem_lsu: RTL

Parametrised data memory with an integrated load/store formatting stage, the next generation of the single-cycle core's data memory. It adds RV32I byte/halfword/word accesses with byte-lane write strobes, sign/zero extension on loads, misalignment and illegal-funct3 fault detection, configurable depth, and an optional wait-state latency with a req/ready handshake. It sits between the ALU address path and the writeback mux. With LATENCY=0 it drops into the single-cycle datapath. With LATENCY>0 it serves a multi-cycle or stalling core.

---
 rtl/mem_pkg.sv | 45 ++++
 rtl/mem_array_be.sv | 33 +++
 rtl/data_mem_lsu.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// +--------------------------------------------------------------------------+
// | mem_pkg : funct3 encodings, FSM states, lane-mask and fault decode.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      LSU_B, LSU_BU: lane_mask = 4'b0001 << off;
      LSU_H, LSU_HU: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      LSU_W:         lane_mask = 4'b1111;
      default:       lane_mask = 4'b0000;
    endcase
  endfunction

  // Unsigned variants exist only for loads, so a store using them is a fault.
  function automatic logic lsu_fault(input logic [2:0] f3, input logic [1:0] off,
                                     input logic is_store);
    case (f3)
      LSU_B:   lsu_fault = 1'b0;
      LSU_H:   lsu_fault = off[0];
      LSU_W:   lsu_fault = |off;
      LSU_BU:  lsu_fault = is_store;
      LSU_HU:  lsu_fault = is_store | off[0];
      default: lsu_fault = 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_array_be.sv
// +--------------------------------------------------------------------------+
// | mem_array_be : DEPTH x 32 storage, byte-lane write enables, async read.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_array_be #(
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/data_mem_lsu.sv
// +--------------------------------------------------------------------------+
// | data_mem_lsu : RV32I load/store formatting over a byte-enabled array,    |
// | with optional wait-state FSM. Rev 1.0                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module data_mem_lsu
  import mem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        ready,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]    arr_we;
  logic [AW-1:0] arr_waddr;
  logic [AW-1:0] arr_raddr;
  logic [31:0]   arr_wdata;
  logic [31:0]   arr_rdata;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^ALUResult[31:AW+2];

  mem_array_be #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .raddr_i (arr_raddr),
    .rdata_o (arr_rdata)
  );

  // Replicate store data across lanes; the lane mask picks the live copy.
  function automatic logic [31:0] store_align(input logic [31:0] wd, input logic [2:0] f3);
    case (f3)
      LSU_B, LSU_BU: store_align = {4{wd[7:0]}};
      LSU_H, LSU_HU: store_align = {2{wd[15:0]}};
      default:       store_align = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_format(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      LSU_B:   load_format = {{24{b[7]}}, b};
      LSU_BU:  load_format = {24'b0, b};
      LSU_H:   load_format = {{16{h[15]}}, h};
      LSU_HU:  load_format = {16'b0, h};
      LSU_W:   load_format = word;
      default: load_format = 32'b0;
    endcase
  endfunction

  generate
    if (LATENCY == 0) begin : g_passthru
      logic w_fault;
      logic unused_rst;

      assign unused_rst = rst;
      assign w_fault    = lsu_fault(funct3, ALUResult[1:0], MemWrite);
      assign arr_raddr  = ALUResult[AW+1:2];
      assign arr_waddr  = ALUResult[AW+1:2];
      assign arr_wdata  = store_align(WriteData, funct3);
      assign arr_we     = (req && MemWrite && !w_fault) ? lane_mask(funct3, ALUResult[1:0]) : 4'b0;
      assign ready      = req;
      assign fault      = req & w_fault;
      assign ReadData   = w_fault ? 32'b0 : load_format(arr_rdata, funct3, ALUResult[1:0]);
    end else begin : g_fsm
      localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

      lsu_state_e    state_q, state_d;
      logic [3:0]    cnt_q, cnt_d;
      logic          we_q;
      logic [2:0]    f3_q;
      logic [AW+1:0] addr_q;
      logic [31:0]   wdata_q;
      logic [31:0]   rdata_q;
      logic          fault_q;

      logic          w_sel_we;
      logic [2:0]    w_sel_f3;
      logic [AW+1:0] w_sel_addr;
      logic          w_fault;
      logic          w_enter_done;

      // With LATENCY=1 the FSM enters DONE straight from IDLE, before the
      // capture registers are valid, so decode from the live inputs then.
      assign w_sel_we     = (state_q == S_IDLE) ? MemWrite : we_q;
      assign w_sel_f3     = (state_q == S_IDLE) ? funct3 : f3_q;
      assign w_sel_addr   = (state_q == S_IDLE) ? ALUResult[AW+1:0] : addr_q;
      assign w_fault      = lsu_fault(w_sel_f3, w_sel_addr[1:0], w_sel_we);
      assign w_enter_done = (state_d == S_DONE) && (state_q != S_DONE);

      assign arr_raddr = w_sel_addr[AW+1:2];
      assign arr_waddr = addr_q[AW+1:2];
      assign arr_wdata = store_align(wdata_q, f3_q);
      assign arr_we    = (state_q == S_DONE && we_q && !fault_q) ? lane_mask(f3_q, addr_q[1:0]) : 4'b0;

      assign ready    = (state_q == S_DONE);
      assign fault    = fault_q;
      assign ReadData = rdata_q;

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
          S_IDLE: begin
            if (req) begin
              cnt_d   = CNT_INIT;
              state_d = (LATENCY == 1) ? S_DONE : S_WAIT;
            end
          end
          S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
              state_d = S_DONE;
            end
          end
          S_DONE:  state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= S_IDLE;
          cnt_q   <= 4'd0;
          rdata_q <= 32'b0;
          fault_q <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          if (w_enter_done) begin
            fault_q <= w_fault;
            rdata_q <= w_fault ? 32'b0 : load_format(arr_rdata, w_sel_f3, w_sel_addr[1:0]);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst && state_q == S_IDLE && req) begin
          we_q    <= MemWrite;
          f3_q    <= funct3;
          addr_q  <= ALUResult[AW+1:0];
          wdata_q <= WriteData;
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire
